// File: rtl/cache_mem_pkg.sv
// Shared types for the cache memory port: request/response bundles and responder state.
// Widths match the direct-mapped cache controller's memory port bit order.
package cache_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int OFF_W  = $clog2(LINE_W / 8);

  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic              valid;
  } mem_req_t;

  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic              ready;
  } mem_data_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } mem_state_e;

endpackage

// File: rtl/cache_line_ram.sv
// Single-port synchronous line RAM: one-cycle registered read, write-enable.
// Contents are deliberately not reset; only the controlling FSM is.
module cache_line_ram #(
  parameter int DEPTH = 1024,
  parameter int W     = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/cache_line_mem_responder.sv
// Fixed-latency line memory behind the cache; one-cycle ready pulse per access.
// Define MEM_STATS_EN to add saturating rd_count/wr_count outputs.
module cache_line_mem_responder #(
  parameter int ADDR_W      = cache_mem_pkg::ADDR_W,
  parameter int LINE_W      = cache_mem_pkg::LINE_W,
  parameter int DEPTH_LINES = 1024,
  parameter int LATENCY     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req_valid,
  input  logic              mem_req_rw,
  input  logic [ADDR_W-1:0] mem_req_addr,
  input  logic [LINE_W-1:0] mem_req_data,
  output logic [LINE_W-1:0] mem_data_data,
  output logic              mem_data_ready
`ifdef MEM_STATS_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);

  import cache_mem_pkg::*;

  localparam int OFF_LO = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(DEPTH_LINES);
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  mem_req_t   req;
  mem_data_t  rsp;
  mem_state_e state_q, state_d;

  logic [7:0]       cnt_q;
  logic             rw_q;
  logic [IDX_W-1:0] idx_q;
  logic [LINE_W-1:0] wdata_q, rdata_q, ram_q;
  logic             accept, ram_we, ram_re, resp;
  logic             unused_addr;

  assign req = '{
    data:  mem_req_data,
    addr:  mem_req_addr,
    rw:    mem_req_rw,
    valid: mem_req_valid
  };

  assign unused_addr = ^{req.addr[ADDR_W-1:OFF_LO+IDX_W],
                         req.addr[OFF_LO-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ram_we  = 1'b0;
    ram_re  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req.valid) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          state_d = RESP;
          ram_re  = !rw_q;
        end
      end
      RESP: begin
        state_d = IDLE;
        ram_we  = rw_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request fields are latched at accept; the live inputs are ignored afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        cnt_q   <= CNT_INIT;
        rw_q    <= req.rw;
        idx_q   <= req.addr[OFF_LO +: IDX_W];
        wdata_q <= req.data;
      end else if (state_q == BUSY && cnt_q != 8'd0) begin
        cnt_q <= cnt_q - 8'd1;
      end
      if (resp && !rw_q)
        rdata_q <= ram_q;
    end
  end

  cache_line_ram #(
    .DEPTH (DEPTH_LINES),
    .W     (LINE_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (ram_q)
  );

  // Read data comes straight from the RAM during RESP, then is held in rdata_q.
  assign resp      = (state_q == RESP);
  assign rsp.ready = resp;
  assign rsp.data  = (resp && !rw_q) ? ram_q : rdata_q;

  assign mem_data_data  = rsp.data;
  assign mem_data_ready = rsp.ready;

`ifdef MEM_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (resp) begin
      if (rw_q) begin
        if (wr_count != 32'hFFFF_FFFF)
          wr_count <= wr_count + 32'd1;
      end else begin
        if (rd_count != 32'hFFFF_FFFF)
          rd_count <= rd_count + 32'd1;
      end
    end
  end
`endif

endmodule
